// File: rtl/clp_pkg.sv
// Shared definitions for the CLP host-side instruction loader: FSM states,
// error codes and default memory geometry.
package clp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD      = 3'd1,
    ST_START     = 3'd2,
    ST_WAIT_BUSY = 3'd3,
    ST_WAIT_IDLE = 3'd4
  } clp_state_e;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_OVERFLOW = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd2;

  localparam int CLP_INSTR_W = 64;
  localparam int CLP_ADDR_W  = 10;

endpackage

// File: rtl/pulse_timer.sv
// Load-and-count-down timer with a zero flag; counts down to 0 and holds
// there until reloaded.
module pulse_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/instr_loader.sv
// Streams host instruction words into the CLP instruction memory, then
// starts the accelerator and follows CLP_state until it returns to idle.
module instr_loader
  import clp_pkg::*;
#(
  parameter int ADDR_W       = CLP_ADDR_W,
  parameter int INSTR_W      = CLP_INSTR_W,
  parameter int ACC_PULSE    = 10,
  parameter int BUSY_TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [INSTR_W-1:0] s_data,
  input  logic               s_last,
  output logic               load_instr_enable,
  output logic [ADDR_W-1:0]  load_instr_addr,
  output logic [INSTR_W-1:0] instr_data,
  output logic               acc_enable,
  input  logic               CLP_state,
  output logic               busy,
  output logic               done,
  output logic [1:0]         err,
  output logic [ADDR_W:0]    instr_count,
  output clp_state_e         state_dbg
);

  localparam int TMR_MAX = (ACC_PULSE > BUSY_TIMEOUT) ? ACC_PULSE : BUSY_TIMEOUT;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam logic [TMR_W-1:0] PULSE_LD   = TMR_W'(ACC_PULSE - 1);
  localparam logic [TMR_W-1:0] TIMEOUT_LD = TMR_W'(BUSY_TIMEOUT - 1);
  // Word count that means every address has been written.
  localparam logic [ADDR_W:0] FULL_COUNT = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE_COUNT  = {{ADDR_W{1'b0}}, 1'b1};

  clp_state_e       state;
  logic             accept;
  logic             tmr_load;
  logic [TMR_W-1:0] tmr_val;
  logic             tmr_zero;

  // Handshake: a word transfers on a rising edge where s_valid and s_ready
  // are both 1; s_data/s_last are ignored otherwise. s_ready is registered
  // and never depends on s_valid.
  assign accept    = s_valid && s_ready;
  assign state_dbg = state;

  // The timer is loaded when the pulse starts (first START cycle) and again
  // when the pulse ends, to run the busy timeout.
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = '0;
    if (state == ST_START) begin
      if (!acc_enable) begin
        tmr_load = 1'b1;
        tmr_val  = PULSE_LD;
      end else if (tmr_zero) begin
        tmr_load = 1'b1;
        tmr_val  = TIMEOUT_LD;
      end
    end
  end

  pulse_timer #(.W(TMR_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= ST_IDLE;
      s_ready           <= 1'b0;
      load_instr_enable <= 1'b0;
      load_instr_addr   <= '0;
      instr_data        <= '0;
      acc_enable        <= 1'b0;
      busy              <= 1'b0;
      done              <= 1'b0;
      err               <= ERR_NONE;
      instr_count       <= '0;
    end else begin
      load_instr_enable <= 1'b0;
      done              <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          s_ready <= 1'b1;
          if (accept) begin
            load_instr_enable <= 1'b1;
            load_instr_addr   <= '0;
            instr_data        <= s_data;
            instr_count       <= ONE_COUNT;
            err               <= ERR_NONE;
            busy              <= 1'b1;
            if (s_last) begin
              state   <= ST_START;
              s_ready <= 1'b0;
            end else begin
              state <= ST_LOAD;
            end
          end
        end
        ST_LOAD: begin
          if (accept) begin
            load_instr_enable <= 1'b1;
            load_instr_addr   <= instr_count[ADDR_W-1:0];
            instr_data        <= s_data;
            instr_count       <= instr_count + 1'b1;
            if (s_last) begin
              state   <= ST_START;
              s_ready <= 1'b0;
            end else if (instr_count + 1'b1 == FULL_COUNT) begin
              // Memory is full but the program has not ended: abandon it.
              err   <= ERR_OVERFLOW;
              state <= ST_IDLE;
              busy  <= 1'b0;
            end
          end
        end
        ST_START: begin
          if (!acc_enable) begin
            acc_enable <= 1'b1;
          end else if (tmr_zero) begin
            acc_enable <= 1'b0;
            state      <= ST_WAIT_BUSY;
          end
        end
        ST_WAIT_BUSY: begin
          if (CLP_state) begin
            state <= ST_WAIT_IDLE;
          end else if (tmr_zero) begin
            err     <= ERR_TIMEOUT;
            state   <= ST_IDLE;
            busy    <= 1'b0;
            s_ready <= 1'b1;
          end
        end
        ST_WAIT_IDLE: begin
          if (!CLP_state) begin
            done    <= 1'b1;
            state   <= ST_IDLE;
            busy    <= 1'b0;
            s_ready <= 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_loader.sv
// Randomized scoreboard bench for instr_loader: expected memory writes are
// queued by the driver and popped by an independent write monitor.
module tb_instr_loader;
  import clp_pkg::*;

  localparam int ADDR_W       = 10;
  localparam int INSTR_W      = 64;
  localparam int ACC_PULSE    = 10;
  localparam int BUSY_TIMEOUT = 64;
  localparam int HS_TO        = 200;
  localparam int RUN_TO       = 2000;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               s_valid = 1'b0;
  logic               s_last = 1'b0;
  logic [INSTR_W-1:0] s_data = '0;
  logic               CLP_state = 1'b0;
  logic               s_ready;
  logic               load_instr_enable;
  logic [ADDR_W-1:0]  load_instr_addr;
  logic [INSTR_W-1:0] instr_data;
  logic               acc_enable;
  logic               busy;
  logic               done;
  logic [1:0]         err;
  logic [ADDR_W:0]    instr_count;
  clp_state_e         state_dbg;

  int n_checks = 0;
  int n_fail = 0;
  logic [ADDR_W+INSTR_W-1:0] exp_q[$];

  int   cyc = 0;
  int   pulse_count = 0;
  int   last_len = 0;
  int   cur_len = 0;
  int   rise_cyc = -1;
  int   last_wr_cyc = -1;
  int   last_wr_addr = -1;
  int   done_count = 0;
  logic acc_prev = 1'b0;
  logic clp_stall = 1'b0;

  instr_loader #(
    .ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .ACC_PULSE(ACC_PULSE), .BUSY_TIMEOUT(BUSY_TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_last(s_last), .load_instr_enable(load_instr_enable), .load_instr_addr(load_instr_addr),
    .instr_data(instr_data), .acc_enable(acc_enable), .CLP_state(CLP_state), .busy(busy),
    .done(done), .err(err), .instr_count(instr_count), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset helpers ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic void check(string name, logic [127:0] act, logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (load_instr_enable) begin
      last_wr_cyc  = cyc;
      last_wr_addr = int'(load_instr_addr);
      check("write_expected", exp_q.size() != 0, 1'b1);
      if (exp_q.size() != 0) check("write_addr_data", {load_instr_addr, instr_data}, exp_q.pop_front());
    end
    if (acc_enable && !acc_prev) begin
      rise_cyc = cyc;
      cur_len  = 0;
    end
    if (acc_enable) cur_len++;
    if (!acc_enable && acc_prev) begin
      pulse_count++;
      last_len = cur_len;
    end
    acc_prev = acc_enable;
    if (done) done_count++;
  end

  // CLP model: busy 3 cycles after acc_enable rises, idle 20 cycles later.
  always begin
    @(posedge acc_enable);
    if (!clp_stall) begin
      repeat (3) @(negedge clk);
      CLP_state = 1'b1;
      repeat (20) @(negedge clk);
      CLP_state = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_word(input logic [INSTR_W-1:0] d, input logic last, input int idx, input int gap);
    int w;
    w = 0;
    if (gap > 0) begin
      s_valid = 1'b0;
      repeat (gap) @(negedge clk);
    end
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    while (!s_ready && w < HS_TO) begin
      @(negedge clk);
      w++;
    end
    check("handshake_in_time", s_ready, 1'b1);
    if (s_ready) begin
      exp_q.push_back({idx[ADDR_W-1:0], d});
      @(negedge clk);
    end else begin
      s_valid = 1'b0;
    end
  endtask

  task automatic send_prog(input int n, input int gapmax, input logic with_last, input logic first_gap0);
    int gap;
    for (int i = 0; i < n; i++) begin
      gap = (gapmax == 0 || (i == 0 && first_gap0)) ? 0 : int'($urandom_range(0, gapmax));
      send_word({$urandom, $urandom}, with_last && (i == n - 1), i, gap);
      if (i == 0) check("err_cleared_on_first", err, ERR_NONE);
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic wait_done();
    int w;
    w = 0;
    while (!done && w < RUN_TO) begin
      @(negedge clk);
      w++;
    end
    check("done_seen", done, 1'b1);
  endtask

  task automatic check_done_cycle(input int n);
    check("ready_in_done_cycle", s_ready, 1'b1);
    check("busy_low_at_done", busy, 1'b0);
    check("idle_at_done", state_dbg, ST_IDLE);
    check("err_at_done", err, ERR_NONE);
    check("instr_count", instr_count, n);
  endtask

  task automatic check_after(input int d_exp, input int p_exp);
    @(negedge clk);
    check("done_one_cycle", done, 1'b0);
    check("done_count", done_count, d_exp);
    check("acc_pulse_count", pulse_count, p_exp);
    check("acc_pulse_len", last_len, ACC_PULSE);
    check("acc_after_last_write", rise_cyc, last_wr_cyc + 1);
  endtask

  task automatic reset_check();
    s_valid = 1'b0;
    s_last  = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("rst_s_ready", s_ready, 1'b0);
    check("rst_wr_en", load_instr_enable, 1'b0);
    check("rst_wr_addr", load_instr_addr, 0);
    check("rst_wr_data", instr_data, 0);
    check("rst_acc_enable", acc_enable, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_err", err, ERR_NONE);
    check("rst_instr_count", instr_count, 0);
    check("rst_state", state_dbg, ST_IDLE);
    exp_q.delete();
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", s_ready, 1'b1);
    check("post_rst_busy", busy, 1'b0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int d0, p0, w, k, n1, n2;

    repeat (3) @(negedge clk);
    reset_check();

    // Two-word program.
    d0 = done_count; p0 = pulse_count;
    send_prog(2, 0, 1'b1, 1'b0);
    wait_done();
    check_done_cycle(2);
    check_after(d0 + 1, p0 + 1);
    repeat (5) @(negedge clk);

    // Stalled CLP: start timeout, no done.
    clp_stall = 1'b1;
    d0 = done_count; p0 = pulse_count;
    send_prog(4, 0, 1'b1, 1'b0);
    w = 0;
    while (!acc_enable && w < 100) begin @(negedge clk); w++; end
    while (acc_enable && w < 100) begin @(negedge clk); w++; end
    check("acc_fell_in_time", acc_enable, 1'b0);
    k = 0;
    while (err != ERR_TIMEOUT && k < 200) begin @(negedge clk); k++; end
    check("timeout_latency", k, BUSY_TIMEOUT);
    check("timeout_err", err, ERR_TIMEOUT);
    check("timeout_busy", busy, 1'b0);
    check("timeout_ready", s_ready, 1'b1);
    repeat (5) @(negedge clk);
    check("timeout_no_done", done_count, d0);
    check("timeout_pulse_count", pulse_count, p0 + 1);
    clp_stall = 1'b0;

    // Bubbly host, then a second program sent in the done cycle.
    d0 = done_count; p0 = pulse_count;
    n1 = int'($urandom_range(8, 16));
    n2 = int'($urandom_range(4, 12));
    send_prog(n1, 3, 1'b1, 1'b0);
    wait_done();
    check_done_cycle(n1);
    send_prog(n2, 2, 1'b1, 1'b1);
    wait_done();
    check_done_cycle(n2);
    check_after(d0 + 2, p0 + 2);
    repeat (5) @(negedge clk);

    // Full memory.
    d0 = done_count; p0 = pulse_count;
    send_prog(1 << ADDR_W, 0, 1'b1, 1'b0);
    wait_done();
    check_done_cycle(1 << ADDR_W);
    check("full_last_addr", last_wr_addr, (1 << ADDR_W) - 1);
    check_after(d0 + 1, p0 + 1);
    repeat (5) @(negedge clk);

    // Overflow, then recovery with a one-word program.
    p0 = pulse_count;
    send_prog(1 << ADDR_W, 0, 1'b0, 1'b0);
    check("ovf_err", err, ERR_OVERFLOW);
    check("ovf_busy", busy, 1'b0);
    check("ovf_ready", s_ready, 1'b1);
    check("ovf_state", state_dbg, ST_IDLE);
    check("ovf_count", instr_count, 1 << ADDR_W);
    repeat (20) @(negedge clk);
    check("ovf_no_acc", pulse_count, p0);
    check("ovf_err_sticky", err, ERR_OVERFLOW);
    d0 = done_count;
    send_prog(1, 0, 1'b1, 1'b0);
    wait_done();
    check_done_cycle(1);
    check_after(d0 + 1, p0 + 1);
    repeat (5) @(negedge clk);

    // Reset during LOAD.
    p0 = pulse_count;
    send_prog(5, 1, 1'b0, 1'b0);
    check("load_busy", busy, 1'b1);
    reset_check();
    repeat (20) @(negedge clk);
    check("load_rst_no_acc", pulse_count, p0);

    // Reset in the middle of the acc_enable pulse.
    d0 = done_count;
    send_prog(3, 0, 1'b1, 1'b0);
    w = 0;
    while (!acc_enable && w < 100) begin @(negedge clk); w++; end
    repeat (4) @(negedge clk);
    check("mid_pulse_acc", acc_enable, 1'b1);
    reset_check();
    repeat (30) @(negedge clk);
    check("pulse_rst_no_done", done_count, d0);
    check("pulse_rst_idle", state_dbg, ST_IDLE);
    check("pulse_rst_acc_low", acc_enable, 1'b0);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_loader.md
# instr_loader

Host-side instruction writer for the CLP accelerator. It accepts a stream of 64-bit instruction words over a valid/ready handshake and writes them into `top`'s instruction memory through the `load_instr_enable` / `load_instr_addr` / `instr_data` write port. Once the last word is written, it pulses `acc_enable` and tracks `CLP_state` until the accelerator returns to idle. It replaces the hand-driven load and start sequence in the bench, and it is the same path the ARM side uses.

## Interface
Parameters:
- `ADDR_W`, 10: instruction memory address width; depth is 2^ADDR_W.
- `INSTR_W`, 64: instruction word width.
- `ACC_PULSE`, 10: number of cycles `acc_enable` is held high.
- `BUSY_TIMEOUT`, 64: cycles allowed after the pulse ends for `CLP_state` to rise.

Ports:
- `clk`  in  1  — single clock; everything is rising-edge.
- `rst`  in  1  — reset, synchronous and active-high.
- `s_valid`  in  1  — host instruction word valid.
- `s_ready`  out  1  — loader can accept a word.
- `s_data`  in  INSTR_W  — instruction word.
- `s_last`  in  1  — marks the final word of the program.
- `load_instr_enable`  out  1  — instruction memory write strobe.
- `load_instr_addr`  out  ADDR_W  — write address.
- `instr_data`  out  INSTR_W  — write data.
- `acc_enable`  out  1  — accelerator start.
- `CLP_state`  in  1  — 0 means CLP idle, 1 means CLP busy.
- `busy`  out  1  — loader is not in IDLE.
- `done`  out  1  — one-cycle pulse when a run completes.
- `err`  out  2  — sticky error code: 0 none, 1 overflow, 2 start timeout. Cleared on the next accepted first word, or by `rst`.
- `instr_count`  out  ADDR_W+1  — number of words written in the current or last program.

## Operation
States:
- **IDLE**
  - `s_ready`=1, write address is 0.
  - An accepted word goes to LOAD, or to START if `s_last`=1.
- **LOAD**
  - `s_ready`=1.
  - Each accepted word is written at the current address, and the address increments.
  - An accepted word with `s_last`=1 goes to START.
  - If the word at address 2^ADDR_W−1 is accepted with `s_last`=0: set `err`=1, go to IDLE, and do not issue `acc_enable`.
- **START**
  - `s_ready`=0, `acc_enable`=1 for exactly `ACC_PULSE` cycles, then go to WAIT_BUSY.
- **WAIT_BUSY**
  - `s_ready`=0.
  - If `CLP_state`=1, go to WAIT_IDLE.
  - If `BUSY_TIMEOUT` cycles elapse first, set `err`=2, go to IDLE, and do not pulse `done`.
  - If `CLP_state` is already 1 during START, WAIT_BUSY is still entered and leaves on its first cycle.
- **WAIT_IDLE**
  - `s_ready`=0.
  - When `CLP_state`=0, pulse `done` for one cycle and go to IDLE. There is no timeout.

Rules:
- A handshake occurs when `s_valid` and `s_ready` are both 1. `s_data` and `s_last` are sampled only then.
- `instr_count` resets to 0 on the first accepted word and increments per write; it holds after the run.
- Address arithmetic is unsigned ADDR_W bits and never wraps. The overflow check uses the full count width.

## Timing
- Reset values: `s_ready`=0 during `rst`, 1 the cycle after. All other outputs are 0, state is IDLE, counters are 0.
- `rst` asserted mid-load or mid-run aborts immediately. Partially written memory is left as-is, and `acc_enable` drops the same edge.
- Write latency is 1 cycle. A handshake at edge N drives `load_instr_enable`=1 with registered addr and data during cycle N+1. Writes for back-to-back handshakes are back-to-back.
- `acc_enable` rises the cycle after the last write strobe and lasts exactly `ACC_PULSE` cycles.
- `done` is asserted the cycle after `CLP_state` is sampled at 0 in WAIT_IDLE.
- `s_ready` is 1 in IDLE the same cycle `done` is asserted, so a new program can start immediately.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Shared package `clp_pkg` holds:
  - the state enum (IDLE, LOAD, START, WAIT_BUSY, WAIT_IDLE);
  - the `err` code constants;
  - the `INSTR_W` / `ADDR_W` defaults.
- The module is a single block. A sub-module `pulse_timer` (load-and-count-down counter with a zero flag) is shared by the START pulse and the WAIT_BUSY timeout.

## Test plan
- **Two-word program.** Two words (addr 0, 1; `s_last` on the second); CLP model goes busy 3 cycles after `acc_enable` and idle 20 cycles later. Required:
  - write strobes at addr 0 and 1 with matching data;
  - `acc_enable` high for exactly 10 cycles;
  - one `done` pulse;
  - `instr_count`=2, `err`=0.
- **Full memory.** 1024 words, `s_last` on word 1024. Required: last write at addr 1023, `acc_enable` issued, `err`=0.
- **Overflow.** 1025 words with no `s_last` in the first 1024. Required: `err`=1 after word 1024, no `acc_enable`, return to IDLE.
- **Stalled CLP.** `CLP_state` held 0 after the pulse. Required: `err`=2 exactly 64 cycles after `acc_enable` falls, no `done`.
- **Bubbly host plus back-to-back runs.** `s_valid` toggled randomly, then a second program sent during the `done` cycle. Required:
  - writes occur only on handshakes, addresses stay contiguous;
  - the second run starts at addr 0, `err` cleared.
- **Reset mid-operation.** `rst` asserted in LOAD and, separately, mid-`acc_enable` pulse. Required: all outputs 0 the next cycle; IDLE with `s_ready`=1 after `rst` deasserts.
